// File: rtl/prog_loader_pkg.sv
// ----------------------------------------------------------------------------
// prog_loader_pkg
// Shared CPU-side definitions used by the program loader: the default memory
// geometry (1024 bytes of 8 bits) and the loader state encoding.
// ----------------------------------------------------------------------------
package prog_loader_pkg;

  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_START,
    ST_RUN
  } state_e;

endpackage

// File: rtl/prog_loader.sv
// ----------------------------------------------------------------------------
// prog_loader
// Streams a program image from a host into CPU memory, then starts the CPU
// and waits for it to halt.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   load_req       one-cycle load request (honoured in IDLE only)
//   base_addr      first memory address, captured with load_req
//   byte_cnt       bytes to load (0..2**MEMORY_ADDR_WIDTH), captured with load_req
//   abort          synchronous abort back to IDLE
//   s_data/s_valid/s_ready   host byte stream (valid/ready handshake)
//   cpu_halt       CPU has executed HALT
//   mem_addr/mem_dataout/mem_we   registered memory write port
//   bus_own        loader owns the memory bus (external mux select)
//   cpu_start      one-cycle CPU start pulse
//   busy           loader not idle
//   done           one-cycle pulse when the CPU halts after a load
//   checksum       modulo-2**MEMORY_DATA_WIDTH sum of accepted bytes
// ----------------------------------------------------------------------------
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int MEMORY_ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MEMORY_DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load_req,
  input  logic [MEMORY_ADDR_WIDTH-1:0] base_addr,
  input  logic [MEMORY_ADDR_WIDTH:0]   byte_cnt,
  input  logic                         abort,
  input  logic [MEMORY_DATA_WIDTH-1:0] s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic                         cpu_halt,
  output logic [MEMORY_ADDR_WIDTH-1:0] mem_addr,
  output logic [MEMORY_DATA_WIDTH-1:0] mem_dataout,
  output logic                         mem_we,
  output logic                         bus_own,
  output logic                         cpu_start,
  output logic                         busy,
  output logic                         done,
  output logic [MEMORY_DATA_WIDTH-1:0] checksum
);

  localparam logic [MEMORY_ADDR_WIDTH-1:0] ADDR_ONE = {{(MEMORY_ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [MEMORY_ADDR_WIDTH:0]   CNT_ONE  = {{MEMORY_ADDR_WIDTH{1'b0}}, 1'b1};

  state_e                       state;
  logic [MEMORY_ADDR_WIDTH-1:0] wr_addr;    // address of the next accepted byte
  logic [MEMORY_ADDR_WIDTH:0]   remaining;  // bytes still to accept
  logic                         handshake;

  assign handshake = s_valid & s_ready;

  // NOTE: all state and outputs update with non-blocking assignments so every
  // register samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wr_addr     <= '0;
      remaining   <= '0;
      s_ready     <= 1'b0;
      mem_addr    <= '0;
      mem_dataout <= '0;
      mem_we      <= 1'b0;
      bus_own     <= 1'b0;
      cpu_start   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      checksum    <= '0;
    end else begin
      // Strobes default low so each is a single-cycle pulse unless re-armed.
      mem_we    <= 1'b0;
      cpu_start <= 1'b0;
      done      <= 1'b0;

      if (abort) begin
        // Dropping mem_we via the default discards a same-cycle handshake.
        state   <= ST_IDLE;
        s_ready <= 1'b0;
        bus_own <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (load_req) begin
              wr_addr   <= base_addr;
              remaining <= byte_cnt;
              checksum  <= '0;
              busy      <= 1'b1;
              if (byte_cnt == '0) begin
                state     <= ST_START;
                cpu_start <= 1'b1;
              end else begin
                state   <= ST_LOAD;
                s_ready <= 1'b1;
                bus_own <= 1'b1;
              end
            end
          end

          ST_LOAD: begin
            if (handshake) begin
              mem_we      <= 1'b1;
              mem_addr    <= wr_addr;
              mem_dataout <= s_data;
              wr_addr     <= wr_addr + ADDR_ONE;  // wraps at the top of memory
              remaining   <= remaining - CNT_ONE;
              checksum    <= checksum + s_data;
              if (remaining == CNT_ONE) begin
                state   <= ST_FLUSH;
                s_ready <= 1'b0;
              end
            end
          end

          // The final write is on the bus during FLUSH; release it afterwards.
          ST_FLUSH: begin
            state     <= ST_START;
            bus_own   <= 1'b0;
            cpu_start <= 1'b1;
          end

          ST_START: state <= ST_RUN;

          ST_RUN: begin
            if (cpu_halt) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end

          default: begin
            state   <= ST_IDLE;
            s_ready <= 1'b0;
            bus_own <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// ----------------------------------------------------------------------------
// tb_prog_loader
// Self-checking bench for prog_loader. Each load is described by base, count,
// valid pattern and an optional abort/reset point; the expected write list,
// checksum and pulse timing come from plain arithmetic over the byte stream.
// ----------------------------------------------------------------------------
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_req = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [10:0] byte_cnt = '0;
  logic        abort = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        cpu_halt = 1'b0;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_dataout;
  logic        mem_we;
  logic        bus_own;
  logic        cpu_start;
  logic        busy;
  logic        done;
  logic [7:0]  checksum;

  prog_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_req    (load_req),
    .base_addr   (base_addr),
    .byte_cnt    (byte_cnt),
    .abort       (abort),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .cpu_halt    (cpu_halt),
    .mem_addr    (mem_addr),
    .mem_dataout (mem_dataout),
    .mem_we      (mem_we),
    .bus_own     (bus_own),
    .cpu_start   (cpu_start),
    .busy        (busy),
    .done        (done),
    .checksum    (checksum)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observations gathered every cycle, #1 after the rising edge.
  int         cycle = 0;
  int         n_start = 0;
  int         start_cyc = -1;
  int         n_done = 0;
  int         bus_viol = 0;
  logic [9:0] got_addr[$];
  logic [7:0] got_data[$];
  int         got_cyc[$];
  logic [7:0] stim[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
    if (mem_we) begin
      got_addr.push_back(mem_addr);
      got_data.push_back(mem_dataout);
      got_cyc.push_back(cycle);
      if (!bus_own) bus_viol++;
    end
    if (cpu_start) begin
      n_start++;
      start_cyc = cycle;
    end
    if (done) n_done++;
  endtask

  task automatic fill(input int n, input int fixed);
    stim.delete();
    for (int i = 0; i < n; i++)
      stim.push_back(fixed >= 0 ? 8'(fixed) : 8'($urandom));
  endtask

  // mode: 0 continuous valid, 1 valid every other cycle, 2 random valid.
  // stop_kind: 0 run to completion, 1 abort at byte stop_at, 2 reset at byte stop_at.
  task automatic run_load(input string name, input int base, input int cnt, input int mode,
                          input int stop_kind, input int stop_at);
    int idx = 0;
    int k = 0;
    int last_hs = -1;
    int req_cyc;
    int ready_drop = 0;
    int sum = 0;
    int n_exp;
    bit v;

    got_addr.delete(); got_data.delete(); got_cyc.delete();
    n_start = 0; n_done = 0; start_cyc = -1;

    base_addr = 10'(base);
    byte_cnt  = 11'(cnt);
    load_req  = 1'b1;
    tick();
    load_req  = 1'b0;
    base_addr = '0;
    byte_cnt  = '0;
    req_cyc   = cycle;

    if (cnt > 0) begin
      check({name, " s_ready_load"}, 32'(s_ready), 1);
      check({name, " bus_own_load"}, 32'(bus_own), 1);
    end

    while (idx < cnt && k < 400) begin
      if (stop_kind != 0 && idx == stop_at) break;
      case (mode)
        0:       v = 1'b1;
        1:       v = (k % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      if (!s_ready) ready_drop++;
      s_valid = v;
      s_data  = v ? stim[idx] : 8'($urandom);
      tick();
      k++;
      if (v) begin
        idx++;
        last_hs = cycle;
      end
    end
    s_valid = 1'b0;
    check({name, " ready_held"}, 32'(ready_drop), 0);

    if (stop_kind == 1) begin
      // Offer a byte in the abort cycle: it must not be written.
      s_valid = 1'b1;
      s_data  = stim[idx];
      abort   = 1'b1;
      tick();
      abort   = 1'b0;
      s_valid = 1'b0;
      check({name, " busy_after_abort"}, 32'(busy), 0);
      check({name, " s_ready_after_abort"}, 32'(s_ready), 0);
      check({name, " bus_own_after_abort"}, 32'(bus_own), 0);
    end else if (stop_kind == 2) begin
      rst_n = 1'b0;
      #2;
      check({name, " busy_in_reset"}, 32'(busy), 0);
      check({name, " mem_we_in_reset"}, 32'(mem_we), 0);
      check({name, " s_ready_in_reset"}, 32'(s_ready), 0);
      rst_n = 1'b1;
    end

    if (stop_kind != 0) begin
      repeat (4) tick();
      n_exp = stop_at;
      check({name, " no_cpu_start"}, 32'(n_start), 0);
      check({name, " no_done"}, 32'(n_done), 0);
      check({name, " idle"}, 32'(busy), 0);
    end else begin
      k = 0;
      while (n_start == 0 && k < 10) begin
        tick();
        k++;
      end
      check({name, " start_time"}, 32'(start_cyc), 32'(cnt == 0 ? req_cyc : last_hs + 1));
      check({name, " bus_own_start"}, 32'(bus_own), 0);
      tick();
      check({name, " start_pulse"}, 32'(cpu_start), 0);
      check({name, " start_count"}, 32'(n_start), 1);
      n_exp = cnt;
    end

    check({name, " write_count"}, 32'(got_addr.size()), 32'(n_exp));
    for (int i = 0; i < n_exp && i < got_addr.size(); i++) begin
      check($sformatf("%s addr[%0d]", name, i), 32'(got_addr[i]), 32'((base + i) % 1024));
      check($sformatf("%s data[%0d]", name, i), 32'(got_data[i]), 32'(stim[i]));
      if (mode == 0 && i > 0)
        check($sformatf("%s back_to_back[%0d]", name, i), 32'(got_cyc[i]), 32'(got_cyc[0] + i));
    end
    check({name, " bus_own_with_we"}, 32'(bus_viol), 0);

    if (stop_kind == 0) begin
      for (int i = 0; i < cnt; i++) sum = (sum + stim[i]) % 256;
      check({name, " checksum"}, 32'(checksum), 32'(sum));

      // A request while the CPU runs must not restart anything.
      base_addr = 10'($urandom);
      byte_cnt  = 11'd5;
      load_req  = 1'b1;
      tick();
      load_req  = 1'b0;
      tick();
      check({name, " run_ignores_req_busy"}, 32'(busy), 1);
      check({name, " run_ignores_req_ready"}, 32'(s_ready), 0);
      check({name, " run_ignores_req_start"}, 32'(n_start), 1);

      cpu_halt = 1'b1;
      tick();
      cpu_halt = 1'b0;
      check({name, " done_pulse"}, 32'(done), 1);
      tick();
      check({name, " done_single"}, 32'(done), 0);
      check({name, " done_count"}, 32'(n_done), 1);
      check({name, " idle_after_done"}, 32'(busy), 0);
      check({name, " checksum_holds"}, 32'(checksum), 32'(sum));
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset s_ready", 32'(s_ready), 0);
    check("reset mem_we", 32'(mem_we), 0);
    check("reset mem_addr", 32'(mem_addr), 0);
    check("reset mem_dataout", 32'(mem_dataout), 0);
    check("reset bus_own", 32'(bus_own), 0);
    check("reset cpu_start", 32'(cpu_start), 0);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset checksum", 32'(checksum), 0);
    rst_n = 1'b1;
    tick();

    fill(14, -1);
    stim[0] = 8'h04; stim[1] = 8'hB3; stim[2] = 8'h00; stim[3] = 8'hB1;
    run_load("base32", 32, 14, 0, 0, 0);

    fill(4, 255);
    run_load("ff4", 0, 4, 0, 0, 0);
    check("ff4 checksum_const", 32'(checksum), 32'h0FC);

    fill(4, -1);
    run_load("wrap", 1022, 4, 0, 0, 0);

    fill(6, -1);
    run_load("alternate", $urandom_range(0, 1023), 6, 1, 0, 0);

    for (int t = 0; t < 3; t++) begin
      fill(40, -1);
      run_load($sformatf("random%0d", t), $urandom_range(0, 1023), $urandom_range(1, 40), 2, 0, 0);
    end

    fill(10, -1);
    run_load("abort3", 100, 10, 0, 1, 3);

    fill(10, -1);
    run_load("reset3", 200, 10, 0, 2, 3);

    fill(0, -1);
    run_load("count0", 5, 0, 0, 0, 0);

    // abort together with load_req in IDLE keeps the loader idle.
    n_start = 0;
    base_addr = 10'd50;
    byte_cnt  = 11'd3;
    load_req  = 1'b1;
    abort     = 1'b1;
    tick();
    load_req  = 1'b0;
    abort     = 1'b0;
    check("abort_wins busy", 32'(busy), 0);
    check("abort_wins s_ready", 32'(s_ready), 0);
    tick();
    check("abort_wins no_start", 32'(n_start), 0);

    // A fresh load works after the abort.
    fill(5, -1);
    run_load("after_abort", 1020, 5, 2, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
